// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: shared types and constants for the execute stage.
//   - aluop_e : ALUOp codes from the main decoder
//   - ctrl_e  : 4-bit ALU control codes
//   - mop_e   : RV32M operation, numerically equal to funct3
//   - state_e : execute FSM state
//   - F7_BASE / F7_ALT / F7_MEXT : recognised funct7 encodings
package alu_exec_pkg;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_ITYPE = 2'b11
  } aluop_e;

  typedef enum logic [3:0] {
    CTRL_ADD  = 4'b0000,
    CTRL_SUB  = 4'b0001,
    CTRL_AND  = 4'b0010,
    CTRL_SLT  = 4'b0011,
    CTRL_SLL  = 4'b0100,
    CTRL_XOR  = 4'b0101,
    CTRL_SRL  = 4'b0110,
    CTRL_SRA  = 4'b0111,
    CTRL_OR   = 4'b1000,
    CTRL_SLTU = 4'b1001
  } ctrl_e;

  typedef enum logic [2:0] {
    M_MUL    = 3'b000,
    M_MULH   = 3'b001,
    M_MULHSU = 3'b010,
    M_MULHU  = 3'b011,
    M_DIV    = 3'b100,
    M_DIVU   = 3'b101,
    M_REM    = 3'b110,
    M_REMU   = 3'b111
  } mop_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

endpackage

// File: rtl/alu_ctrl_dec.sv
// alu_ctrl_dec: combinational decode of ALUOp/funct3/funct7.
// Macro: ALU_EXEC_MDU_EN -- when defined, funct7=0000001 on R-type marks an
//   RV32M op (is_mext); when undefined that encoding is illegal.
// Ports:
//   alu_op  in  2  ALUOp from main decoder
//   funct3  in  3  instruction funct3
//   funct7  in  7  instruction funct7
//   ctrl    out 4  ALU control code
//   is_mext out 1  RV32M operation (mop = funct3)
//   illegal out 1  undecodable funct7 for this op
module alu_ctrl_dec
  import alu_exec_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output ctrl_e      ctrl,
  output logic       is_mext,
  output logic       illegal
);

  logic rtype;
  logic f7_checked;

  always_comb begin
    ctrl       = CTRL_ADD;
    is_mext    = 1'b0;
    illegal    = 1'b0;
    rtype      = (alu_op == ALUOP_RTYPE);
    // I-type only carries a funct7 field on shift-immediates
    f7_checked = rtype || (funct3 == 3'b001) || (funct3 == 3'b101);
    case (aluop_e'(alu_op))
      ALUOP_ADD: ctrl = CTRL_ADD;
      ALUOP_SUB: ctrl = CTRL_SUB;
      default: begin
        case (funct3)
          3'b000:  ctrl = (rtype && funct7 == F7_ALT) ? CTRL_SUB : CTRL_ADD;
          3'b001:  ctrl = CTRL_SLL;
          3'b010:  ctrl = CTRL_SLT;
          3'b011:  ctrl = CTRL_SLTU;
          3'b100:  ctrl = CTRL_XOR;
          3'b101:  ctrl = (funct7 == F7_ALT) ? CTRL_SRA : CTRL_SRL;
          3'b110:  ctrl = CTRL_OR;
          default: ctrl = CTRL_AND;
        endcase
        if (f7_checked) begin
          if (rtype && funct7 == F7_MEXT) begin
`ifdef ALU_EXEC_MDU_EN
            is_mext = 1'b1;
`else
            illegal = 1'b1;
`endif
          end else if (funct7 != F7_BASE && funct7 != F7_ALT) begin
            illegal = 1'b1;
          end
        end
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: registered execute stage. RV32I ALU ops complete in one
// cycle; RV32M ops (optional) iterate MDU_STEP bits per cycle.
// Macro: ALU_EXEC_MDU_EN -- enables the mul/div iterator and the CALC state.
// Ports:
//   clk, rst_n           clock (rising) / async active-low reset
//   in_valid, in_ready   operation handshake
//   alu_op, funct3, funct7, op_a, op_b   operation and operands
//   out_valid, out_ready result handshake
//   result               registered result
//   illegal              undecodable op (qualified by out_valid)
//   busy                 FSM not idle
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MDU_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);

  ctrl_e           dec_ctrl;
  logic            dec_mext;
  logic            dec_illegal;
  state_e          state_q, state_d;
  logic            accept;
  logic            go_calc;
  logic            mdu_last;
  logic            mdu_fin;
  logic [XLEN-1:0] imm_result;
  logic [XLEN-1:0] mdu_result;

  alu_ctrl_dec u_dec (
    .alu_op  (alu_op),
    .funct3  (funct3),
    .funct7  (funct7),
    .ctrl    (dec_ctrl),
    .is_mext (dec_mext),
    .illegal (dec_illegal)
  );

  function automatic logic [XLEN-1:0] alu_calc(input ctrl_e c,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [SHW-1:0]         sh;
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    sh = b[SHW-1:0];
    sa = a;
    sb = b;
    case (c)
      CTRL_ADD:  return a + b;
      CTRL_SUB:  return a - b;
      CTRL_AND:  return a & b;
      CTRL_OR:   return a | b;
      CTRL_XOR:  return a ^ b;
      CTRL_SLT:  return {{(XLEN-1){1'b0}}, (sa < sb)};
      CTRL_SLTU: return {{(XLEN-1){1'b0}}, (a < b)};
      CTRL_SLL:  return a << sh;
      CTRL_SRL:  return a >> sh;
      CTRL_SRA:  return sa >>> sh;
      default:   return '0;
    endcase
  endfunction

  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign mdu_fin   = (state_q == ST_CALC) && mdu_last;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = go_calc ? ST_CALC : ST_DONE;
      ST_CALC: if (mdu_last) state_d = ST_DONE;
      ST_DONE: begin
        if (out_ready) state_d = accept ? (go_calc ? ST_CALC : ST_DONE) : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

`ifdef ALU_EXEC_MDU_EN
  localparam int NITER = XLEN / MDU_STEP;
  localparam int CW    = $clog2(NITER) + 1;

  // One shift-add step: low half holds the unconsumed multiplier bits.
  function automatic logic [2*XLEN-1:0] mul_step(input logic [2*XLEN-1:0] acc,
                                                 input logic [XLEN-1:0] m);
    logic [XLEN:0] sum;
    sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? m : {XLEN{1'b0}})};
    return {sum, acc[XLEN-1:1]};
  endfunction

  // One restoring step: {remainder, dividend/quotient} shifts left together.
  function automatic logic [2*XLEN-1:0] div_step(input logic [2*XLEN-1:0] acc,
                                                 input logic [XLEN-1:0] d);
    logic [XLEN:0]   hi;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] lo;
    hi   = acc[2*XLEN-1:XLEN-1];
    lo   = {acc[XLEN-2:0], 1'b0};
    diff = hi - {1'b0, d};
    if (!diff[XLEN]) begin
      hi    = diff;
      lo[0] = 1'b1;
    end
    return {hi[XLEN-1:0], lo};
  endfunction

  mop_e              dec_mop, mop_p1;
  logic              is_div, a_sgn, b_sgn, div_zero, div_ovf;
  logic [XLEN-1:0]   a_mag, b_mag, spec_result;
  logic [2*XLEN-1:0] acc_p1, acc_nx, prod;
  logic [XLEN-1:0]   opnd_p1, quo, rem;
  logic              negq_p1, negr_p1, div_p1;
  logic [CW-1:0]     cnt_p1;

  // p0: operand conditioning on the accept cycle
  always_comb begin
    dec_mop  = mop_e'(funct3);
    is_div   = funct3[2];
    a_sgn    = op_a[XLEN-1] && (dec_mop inside {M_MULH, M_MULHSU, M_DIV, M_REM});
    b_sgn    = op_b[XLEN-1] && (dec_mop inside {M_MULH, M_DIV, M_REM});
    a_mag    = a_sgn ? -op_a : op_a;
    b_mag    = b_sgn ? -op_b : op_b;
    div_zero = (op_b == '0);
    div_ovf  = (dec_mop inside {M_DIV, M_REM}) &&
               (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    // funct3[1] separates REM/REMU from DIV/DIVU
    spec_result = '0;
    if (div_zero)     spec_result = funct3[1] ? op_a : '1;
    else if (div_ovf) spec_result = funct3[1] ? '0 : op_a;
    go_calc = dec_mext && !(is_div && (div_zero || div_ovf));
    if (dec_illegal)   imm_result = '0;
    else if (dec_mext) imm_result = spec_result;
    else               imm_result = alu_calc(dec_ctrl, op_a, op_b);
  end

  always_ff @(posedge clk) begin
    if (accept && go_calc) begin
      acc_p1  <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
      opnd_p1 <= is_div ? b_mag : a_mag;
      mop_p1  <= dec_mop;
      div_p1  <= is_div;
      negq_p1 <= a_sgn ^ b_sgn;
      negr_p1 <= a_sgn;
    end else if (state_q == ST_CALC) begin
      acc_p1 <= acc_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 cnt_p1 <= '0;
    else if (accept && go_calc)                 cnt_p1 <= CW'(NITER - 1);
    else if (state_q == ST_CALC && !mdu_last)   cnt_p1 <= cnt_p1 - 1'b1;
  end

  assign mdu_last = (cnt_p1 == '0);

  // p1: iteration and sign fix-up of the finished magnitude
  always_comb begin
    acc_nx = acc_p1;
    for (int i = 0; i < MDU_STEP; i++)
      acc_nx = div_p1 ? div_step(acc_nx, opnd_p1) : mul_step(acc_nx, opnd_p1);
    prod = negq_p1 ? -acc_nx : acc_nx;
    quo  = acc_nx[XLEN-1:0];
    rem  = acc_nx[2*XLEN-1:XLEN];
    case (mop_p1)
      M_MUL:                     mdu_result = prod[XLEN-1:0];
      M_MULH, M_MULHSU, M_MULHU: mdu_result = prod[2*XLEN-1:XLEN];
      M_DIV, M_DIVU:             mdu_result = negq_p1 ? -quo : quo;
      default:                   mdu_result = negr_p1 ? -rem : rem;
    endcase
  end
`else
  assign go_calc    = 1'b0;
  assign mdu_last   = 1'b1;
  assign mdu_result = '0;
  always_comb begin
    imm_result = (dec_illegal || dec_mext) ? '0 : alu_calc(dec_ctrl, op_a, op_b);
  end
`endif

  // p1: output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result  <= '0;
      illegal <= 1'b0;
    end else if (accept && !go_calc) begin
      result  <= imm_result;
      illegal <= dec_illegal;
    end else if (mdu_fin) begin
      result  <= mdu_result;
      illegal <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and randomized bench for alu_exec_unit with a
// behavioural reference model and a per-cycle compare process.
// Macro: ALU_EXEC_MDU_EN -- selects the RV32M expectations.
module tb_alu_exec_unit;

`ifdef ALU_EXEC_MDU_EN
  localparam bit MDU = 1'b1;
`else
  localparam bit MDU = 1'b0;
`endif
  localparam int LAT_M = 32 / 1 + 1;

  typedef struct {
    logic [31:0] r;
    logic        ill;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, illegal, busy;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] op_a, op_b, result;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  exp_t q[$];

  alu_exec_unit #(.XLEN(32), .MDU_STEP(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model straight from the ISA definitions, using 64-bit arithmetic.
  function automatic exp_t model(input logic [1:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t               e;
    longint             sa, sb, ua, p;
    logic [63:0]        pu;
    logic signed [31:0] sa32;
    logic [31:0]        sra;
    e.r = 32'h0; e.ill = 1'b0; e.lat = 1; e.acc = 0;
    sa = longint'($signed(a)); sb = longint'($signed(b)); ua = longint'({32'h0, a});
    sa32 = a;
    sra  = sa32 >>> b[4:0];
    if (op == 2'b00) e.r = a + b;
    else if (op == 2'b01) e.r = a - b;
    else if (op == 2'b10 && f7 == 7'h01 && MDU) begin
      case (f3)
        3'd0: begin p = sa * sb; e.r = p[31:0]; e.lat = LAT_M; end
        3'd1: begin p = sa * sb; e.r = p[63:32]; e.lat = LAT_M; end
        3'd2: begin p = sa * ua; e.r = p[63:32]; e.lat = LAT_M; end
        3'd3: begin pu = {32'h0, a} * {32'h0, b}; e.r = pu[63:32]; e.lat = LAT_M; end
        3'd4: begin
          if (b == 0) e.r = 32'hFFFFFFFF;
          else if (a == 32'h80000000 && b == 32'hFFFFFFFF) e.r = 32'h80000000;
          else begin p = sa / sb; e.r = p[31:0]; e.lat = LAT_M; end
        end
        3'd5: begin
          if (b == 0) e.r = 32'hFFFFFFFF;
          else begin e.r = a / b; e.lat = LAT_M; end
        end
        3'd6: begin
          if (b == 0) e.r = a;
          else if (a == 32'h80000000 && b == 32'hFFFFFFFF) e.r = 32'h0;
          else begin p = sa % sb; e.r = p[31:0]; e.lat = LAT_M; end
        end
        default: begin
          if (b == 0) e.r = a;
          else begin e.r = a % b; e.lat = LAT_M; end
        end
      endcase
    end else if ((op == 2'b10 || f3 == 3'd1 || f3 == 3'd5) && f7 != 7'h00 && f7 != 7'h20)
      e.ill = 1'b1;
    else begin
      case (f3)
        3'd0:    e.r = (op == 2'b10 && f7 == 7'h20) ? a - b : a + b;
        3'd1:    e.r = a << b[4:0];
        3'd2:    e.r = {31'h0, ($signed(a) < $signed(b))};
        3'd3:    e.r = {31'h0, (a < b)};
        3'd4:    e.r = a ^ b;
        3'd5:    e.r = (f7 == 7'h20) ? sra : (a >> b[4:0]);
        3'd6:    e.r = a | b;
        default: e.r = a & b;
      endcase
    end
    return e;
  endfunction

  // Compare process: queue holds accepted ops in order; front becomes
  // visible lat cycles after acceptance and leaves when consumed.
  always @(negedge clk) begin
    logic exp_ov, exp_ir;
    exp_t e;
    if (!rst_n) q.delete();
    else begin
      exp_ov = (q.size() > 0) && (cyc - q[0].acc >= q[0].lat);
      exp_ir = (q.size() == 0) || (exp_ov && out_ready);
      chk("mon_out_valid", {31'h0, out_valid}, {31'h0, exp_ov});
      chk("mon_in_ready", {31'h0, in_ready}, {31'h0, exp_ir});
      chk("mon_busy", {31'h0, busy}, {31'h0, (q.size() > 0)});
      if (exp_ov) begin
        chk("mon_result", result, q[0].r);
        chk("mon_illegal", {31'h0, illegal}, {31'h0, q[0].ill});
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && exp_ir) begin
        e = model(alu_op, funct3, funct7, op_a, op_b);
        e.acc = cyc;
        q.push_back(e);
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] a, input logic [31:0] b);
    alu_op = op; funct3 = f3; funct7 = f7; op_a = a; op_b = b; in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    chk("send_timeout", 32'h0, 32'h1);
    in_valid = 1'b0;
  endtask

  task automatic directed(input string name, input logic [1:0] op, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input logic exp_ill, input int exp_lat);
    int t;
    out_ready = 1'b1;
    send(op, f3, f7, a, b);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!out_valid && t < 100);
    chk({name, "_lat"}, t, exp_lat);
    chk({name, "_res"}, result, exp_r);
    chk({name, "_ill"}, {31'h0, illegal}, {31'h0, exp_ill});
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      5: return 32'($urandom_range(0, 40));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    exp_t m;
    bit   taken;
    int   t;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = 2'b00; funct3 = 3'd0; funct7 = 7'd0; op_a = 32'h0; op_b = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_illegal", {31'h0, illegal}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Hand-computed values pinning the reference model
    m = model(2'b10, 3'd0, 7'h20, 32'd5, 32'd7);              chk("mdl_sub", m.r, 32'hFFFFFFFE);
    m = model(2'b10, 3'd5, 7'h20, 32'h80000000, 32'd4);       chk("mdl_sra", m.r, 32'hF8000000);
    m = model(2'b10, 3'd3, 7'h00, 32'd1, 32'hFFFFFFFF);       chk("mdl_sltu", m.r, 32'h1);
    m = model(2'b10, 3'd0, 7'h02, 32'd1, 32'd2);              chk("mdl_ill", {31'h0, m.ill}, 32'h1);
`ifdef ALU_EXEC_MDU_EN
    m = model(2'b10, 3'd4, 7'h01, 32'hFFFFFFF9, 32'd2);       chk("mdl_div", m.r, 32'hFFFFFFFD);
    m = model(2'b10, 3'd6, 7'h01, 32'hFFFFFFF9, 32'd2);       chk("mdl_rem", m.r, 32'hFFFFFFFF);
    m = model(2'b10, 3'd3, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF); chk("mdl_mulhu", m.r, 32'hFFFFFFFE);
`endif

    // Directed operations
    directed("sub", 2'b10, 3'd0, 7'h20, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, 1);
    directed("addi_f7", 2'b11, 3'd0, 7'h20, 32'd5, 32'd7, 32'd12, 1'b0, 1);
    directed("slt", 2'b10, 3'd2, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1);
    directed("ill_f7", 2'b10, 3'd0, 7'h02, 32'd9, 32'd3, 32'h0, 1'b1, 1);
    directed("ld_add", 2'b00, 3'd7, 7'h7F, 32'h10, 32'h20, 32'h30, 1'b0, 1);
`ifdef ALU_EXEC_MDU_EN
    directed("div", 2'b10, 3'd4, 7'h01, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, LAT_M);
    directed("rem", 2'b10, 3'd6, 7'h01, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, LAT_M);
    directed("mulhu", 2'b10, 3'd3, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, LAT_M);
    directed("mul", 2'b10, 3'd0, 7'h01, 32'd6, 32'hFFFFFFF9, 32'hFFFFFFD6, 1'b0, LAT_M);
    directed("divu_z", 2'b10, 3'd5, 7'h01, 32'h1234, 32'd0, 32'hFFFFFFFF, 1'b0, 1);
    directed("rem_z", 2'b10, 3'd6, 7'h01, 32'h1234, 32'd0, 32'h1234, 1'b0, 1);
    directed("div_ovf", 2'b10, 3'd4, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1);
`else
    directed("mext_ill", 2'b10, 3'd0, 7'h01, 32'd6, 32'd7, 32'h0, 1'b1, 1);
`endif

    // Back-to-back issue at one op per cycle, then a stalled consumer
    out_ready = 1'b1;
    alu_op = 2'b10; funct3 = 3'd0; funct7 = 7'h00; op_a = 32'd3; op_b = 32'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    funct3 = 3'd5; funct7 = 7'h20; op_a = 32'h80000000; op_b = 32'd4;
    @(negedge clk); chk("b2b_add", result, 32'd7);
    @(posedge clk); #1;
    funct3 = 3'd3; funct7 = 7'h00; op_a = 32'd1; op_b = 32'hFFFFFFFF;
    @(negedge clk); chk("b2b_sra", result, 32'hF8000000);
    @(posedge clk); #1;
    out_ready = 1'b0; funct3 = 3'd4; op_a = 32'hF0F0F0F0; op_b = 32'h0FF00FF0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_result", result, 32'd1);
      chk("stall_in_ready", {31'h0, in_ready}, 32'h0);
      chk("stall_out_valid", {31'h0, out_valid}, 32'h1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk); chk("b2b_xor", result, 32'hFF00FF00);
    @(posedge clk); #1;

    // Randomized traffic with random back-pressure
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      taken = in_valid && in_ready;
      @(posedge clk); #1;
      if (taken || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        alu_op   = 2'($urandom_range(0, 3));
        funct3   = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 5))
          0, 1, 2: funct7 = 7'h00;
          3:       funct7 = 7'h20;
          4:       funct7 = 7'h01;
          default: funct7 = 7'($urandom_range(0, 127));
        endcase
        op_a = pick();
        op_b = pick();
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain", q.size(), 32'h0);

    // Reset in the middle of an operation
`ifdef ALU_EXEC_MDU_EN
    out_ready = 1'b1;
    send(2'b10, 3'd4, 7'h01, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
`else
    out_ready = 1'b0;
    send(2'b00, 3'd0, 7'h00, 32'd100, 32'd7);
    repeat (2) @(negedge clk);
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("mid_rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    @(negedge clk); #2 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (40) @(negedge clk);
    @(posedge clk); #1;
    directed("post_rst", 2'b10, 3'd6, 7'h00, 32'h0F0, 32'h00F, 32'h0FF, 1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
